multicycle_main_ctrl: RTL
=========================

# multicycle_main_ctrl

- Main control FSM of the multicycle MIPS datapath; one FSM step per clock.
- Sequences each instruction through fetch, decode, execute, memory and writeback, and drives every datapath enable and mux select.
- Produces the 2-bit `ALUOp` consumed by the downstream ALU control decoder:
  - 00 = add
  - 01 = sub
  - 10 = R-type, decoded by funct
  - 11 = I-type, decoded by opcode
- Stretches memory states on a `mem_ready` handshake.

## Interface
- No parameters.
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; valid from DECODE onward
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory completes current access this cycle
- PCWrite, PCWriteCond, BranchNE  out  1 each  unconditional PC write; conditional branch write; 1 = bne sense
- IorD, MemRead, MemWrite, IRWrite  out  1 each  address select (0 = PC, 1 = ALUOut); memory strobes; IR load
- RegWrite  out  1  register-file write
- RegDst  out  2  00 rt, 01 rd, 10 $31
- MemtoReg  out  2  00 ALUOut, 01 MDR, 10 PC
- ALUSrcA  out  1  0 PC, 1 A
- ALUSrcB  out  2  00 B, 01 const 4, 10 ext imm, 11 ext imm<<2
- ALUOp  out  2  see summary
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 A (jr)
- illegal  out  1  one-cycle pulse on an undecodable opcode
- state  out  4  current state, for debug

## Operation
- Moore FSM: outputs decode only from the state register, plus `mem_ready` gating. Any output not listed for a state is 0.
- FETCH (0): MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite are asserted only when mem_ready=1.
  - mem_ready=1 -> DECODE; otherwise stay.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 000000 with funct 001000 -> JR
  - other 000000 -> EXEC_R
  - 100011/101011 -> MEMADR
  - 000100/000101 -> BRANCH
  - 000010 -> JUMP
  - 000011 -> JAL (only when MC_JAL_EN is defined)
  - 001xxx -> EXEC_I
  - anything else -> FETCH, with illegal=1 for this cycle
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD, sw -> MEMWR.
- MEMRD (3): MemRead=1, IorD=1; mem_ready -> MEMWB.
- MEMWB (4): RegWrite=1, RegDst=00, MemtoReg=01 -> FETCH.
- MEMWR (5): MemWrite=1, IorD=1; mem_ready -> FETCH.
- EXEC_R (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> RWB.
- RWB (7): RegWrite=1, RegDst=01, MemtoReg=00 -> FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNE=opcode[0] -> FETCH.
- JUMP (9): PCWrite=1, PCSource=10 -> FETCH.
- EXEC_I (10): ALUSrcA=1, ALUSrcB=10, ALUOp=11 -> IWB.
- IWB (11): RegWrite=1, RegDst=00, MemtoReg=00 -> FETCH.
- JR (12): PCWrite=1, PCSource=11 -> FETCH.
- JAL (13): PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10 -> FETCH. The PC used is already PC+4 from FETCH.
- Encodings 14 and 15 -> FETCH.

## Timing
- Reset: state=FETCH. While rst_n=0, PCWrite, IRWrite, RegWrite and MemWrite are forced to 0 regardless of mem_ready. Other outputs hold their FETCH values: MemRead=1, ALUSrcB=01, the rest 0.
- Release of reset: the first rising edge with rst_n=1 evaluates FETCH normally.
- Reset asserted mid-instruction: immediate return to FETCH. No partial writeback completes.
- Cycle counts with mem_ready held at 1:
  - 5 cycles: lw
  - 4 cycles: sw, R-type, I-type
  - 3 cycles: beq, bne, j, jr, jal
  - 2 cycles: illegal opcode
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Strobes stay steady for the whole wait.
- mem_ready is ignored in all other states.
- Strobes are never asserted in a state other than those listed above.

## Configuration
- Macro: MC_JAL_EN.
- Defined: opcode 000011 -> JAL state, as specified above.
- Undefined:
  - the JAL state is not compiled
  - 000011 is handled as illegal (illegal pulse, return to FETCH)
  - RegDst=10 and MemtoReg=10 are never driven

## Test plan
- Reset: rst_n=0 with mem_ready=1 -> state=0, PCWrite=IRWrite=RegWrite=MemWrite=0, MemRead=1, ALUSrcB=01.
- lw (opcode 100011), mem_ready=1 -> states 0,1,2,3,4,0. ALUOp 00 in MEMADR. RegWrite=1 with MemtoReg=01 in cycle 5 only.
- sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 and IorD=1 held for 4 cycles, then FETCH.
- R-type add (funct 100000) -> ALUOp=10 in EXEC_R, RegDst=01 in RWB. jr (funct 001000) -> PCSource=11 in cycle 3.
- bne (000101) -> BRANCH with BranchNE=1, PCWriteCond=1, ALUOp=01. ori (001101) -> ALUOp=11 in EXEC_I.
- Opcode 111111 -> illegal=1 in DECODE, FETCH next. Opcode 000011 -> JAL when MC_JAL_EN is defined, illegal when undefined. Reset pulsed in MEMRD -> FETCH, no RegWrite.

Source files
------------

// File: rtl/multicycle_main_ctrl.sv
// multicycle_main_ctrl: main control FSM of the multicycle MIPS datapath; jal support is enabled by defining MC_JAL_EN
module multicycle_main_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       BranchNE,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC_R = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_EXEC_I = 4'd10,
        S_IWB    = 4'd11,
`ifdef MC_JAL_EN
        S_JR     = 4'd12,
        S_JAL    = 4'd13
`else
        S_JR     = 4'd12
`endif
    } state_t;
    state_t cur, nxt;
    assign state = cur;
    // state register; reset returns straight to FETCH, abandoning any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cur <= S_FETCH;
        else cur <= nxt;
    end
    // next-state and Moore outputs; FETCH write strobes also masked by reset so nothing commits while held
    always_comb begin
        nxt         = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        BranchNE    = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 2'b00;
        MemtoReg    = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        illegal     = 1'b0;
        case (cur)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready & rst_n;
                PCWrite = mem_ready & rst_n;
                nxt     = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                casez (opcode)
                    6'b000000:           nxt = (funct == 6'b001000) ? S_JR : S_EXEC_R;
                    6'b100011, 6'b101011: nxt = S_MEMADR;
                    6'b00010?:           nxt = S_BRANCH;
                    6'b000010:           nxt = S_JUMP;
`ifdef MC_JAL_EN
                    6'b000011:           nxt = S_JAL;
`endif
                    6'b001???:           nxt = S_EXEC_I;
                    default:             illegal = 1'b1;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = opcode[3] ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                nxt     = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 2'b01;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                nxt      = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                nxt     = S_RWB;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 2'b01;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                BranchNE    = opcode[0];
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
                nxt     = S_IWB;
            end
            S_IWB: RegWrite = 1'b1;
            S_JR: begin
                PCWrite  = 1'b1;
                PCSource = 2'b11;
            end
`ifdef MC_JAL_EN
            S_JAL: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
            end
`endif
            default: nxt = S_FETCH;
        endcase
    end
endmodule
